wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the in-order writeback stage and an out-of-band multi-cycle unit (mul/div) that returns results late. It sits between the writeback mux output and the register-file write port. The writeback stage always has priority. Multi-cycle results are buffered in a small FIFO and retired into idle write slots. An optional starvation guard forces a one-cycle pipeline stall so that buffered results cannot wait indefinitely.

---
 rtl/wb_port_arbiter_if.sv | 38 +++
 rtl/wb_port_arbiter.sv | 125 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if
//   Bundles the writeback-stage request, the multi-cycle unit handshake, the
//   register-file write port and the pending-entry view for the hazard unit.
//   master : pipeline side (drives WB_* and MC_* requests, observes results)
//   slave  : the arbiter itself
//   Parameters must match those given to wb_port_arbiter.
interface wb_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
);
  logic                    WB_we_i;
  logic [4:0]              WB_rd_addr_i;
  logic [DATA_WIDTH-1:0]   WB_writeback_data_i;
  logic                    MC_valid_i;
  logic [4:0]              MC_rd_addr_i;
  logic [DATA_WIDTH-1:0]   MC_data_i;
  logic                    MC_ready_o;
  logic                    RF_we_o;
  logic [4:0]              RF_waddr_o;
  logic [DATA_WIDTH-1:0]   RF_wdata_o;
  logic [FIFO_DEPTH-1:0]   pend_valid_o;
  logic [5*FIFO_DEPTH-1:0] pend_rd_o;
  logic                    stall_o;

  modport master (
    output WB_we_i, WB_rd_addr_i, WB_writeback_data_i,
    output MC_valid_i, MC_rd_addr_i, MC_data_i,
    input  MC_ready_o, RF_we_o, RF_waddr_o, RF_wdata_o,
    input  pend_valid_o, pend_rd_o, stall_o
  );

  modport slave (
    input  WB_we_i, WB_rd_addr_i, WB_writeback_data_i,
    input  MC_valid_i, MC_rd_addr_i, MC_data_i,
    output MC_ready_o, RF_we_o, RF_waddr_o, RF_wdata_o,
    output pend_valid_o, pend_rd_o, stall_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between the in-order writeback
//   stage (always priority) and late multi-cycle results, which are buffered
//   in a small FIFO and retired into idle write slots.
//   Ports:
//     clk_i  - clock, rising edge
//     rst_i  - synchronous active-high reset
//     bus    - wb_port_arbiter_if.slave: WB_* request, MC_* handshake,
//              RF_* write port, pend_valid_o/pend_rd_o, stall_o
//   Optional feature: define WB_ARB_STARVE_EN to enable the starvation guard
//   (counter + stall_o). Undefined: stall_o is tied low and the FIFO drains
//   only into free slots.
module wb_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  wb_port_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]          rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]          occ;
  logic [4:0]              addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   data_q [FIFO_DEPTH];

  logic empty, full, slot_busy, push, pop, stall;
  logic [PTR_W-1:0] rd_idx, wr_idx;

  assign rd_idx    = rd_ptr_q[PTR_W-1:0];
  assign wr_idx    = wr_ptr_q[PTR_W-1:0];
  assign occ       = wr_ptr_q - rd_ptr_q;
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx == rd_idx);
  assign slot_busy = bus.WB_we_i && (bus.WB_rd_addr_i != 5'd0);

  // Ready comes from registered fullness only; a pop this cycle does not
  // open a slot for a same-cycle push.
  assign bus.MC_ready_o = !full;
  // Writes to x0 complete the handshake but are never stored.
  assign push = bus.MC_valid_i && !full && (bus.MC_rd_addr_i != 5'd0);
  assign pop  = !empty && (stall || !slot_busy);

`ifdef WB_ARB_STARVE_EN
  logic [7:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (empty || pop)
      starve_cnt_d = 8'd0;
    else if (starve_cnt_q != 8'(STARVE_LIMIT))
      starve_cnt_d = starve_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) starve_cnt_q <= 8'd0;
    else       starve_cnt_q <= starve_cnt_d;
  end

  assign stall = (starve_cnt_q == 8'(STARVE_LIMIT));
`else
  assign stall = 1'b0;
`endif

  assign bus.stall_o = stall;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) addr_q[i] <= 5'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) addr_q[wr_idx] <= bus.MC_rd_addr_i;
    end
  end

  // Data storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push) data_q[wr_idx] <= bus.MC_data_i;
  end

  // Single write port mux: stall forces the FIFO head, otherwise the
  // pipeline wins, otherwise an idle slot drains the FIFO.
  always_comb begin
    bus.RF_we_o    = 1'b0;
    bus.RF_waddr_o = 5'd0;
    bus.RF_wdata_o = '0;
    if (stall || (!slot_busy && !empty)) begin
      bus.RF_we_o    = !empty;
      bus.RF_waddr_o = empty ? 5'd0 : addr_q[rd_idx];
      bus.RF_wdata_o = empty ? '0 : data_q[rd_idx];
    end else if (slot_busy) begin
      bus.RF_we_o    = 1'b1;
      bus.RF_waddr_o = bus.WB_rd_addr_i;
      bus.RF_wdata_o = bus.WB_writeback_data_i;
    end
  end

  // Entry i is live when its distance from the read pointer is below the
  // occupancy; destinations of dead entries read as 0.
  always_comb begin
    logic [PTR_W-1:0] off;
    bus.pend_valid_o = '0;
    bus.pend_rd_o    = '0;
    off              = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off = PTR_W'(i) - rd_idx;
      bus.pend_valid_o[i] = ({1'b0, off} < occ);
      if (bus.pend_valid_o[i]) bus.pend_rd_o[5*i +: 5] = addr_q[i];
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 8;
`ifdef WB_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus();

  wb_port_arbiter #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // current stimulus, kept locally for the model
  logic          c_we, c_mv;
  logic [4:0]    c_wa, c_ma;
  logic [DW-1:0] c_wd, c_md;

  // reference model: ordered list of pending results plus the number of
  // results ever retired (fixes which physical slot each entry occupies)
  typedef struct { logic [4:0] a; logic [DW-1:0] d; } ent_t;
  ent_t q[$];
  int   pops;
  int   sc;

  typedef struct {
    logic we; logic [4:0] wa; logic [DW-1:0] wd;
    logic mv; logic [4:0] ma; logic [DW-1:0] md;
    logic e_we; logic [4:0] e_wa; logic [DW-1:0] e_wd;
    logic e_rdy; logic [DEPTH-1:0] e_pv;
  } vec_t;
  vec_t tbl[19];

  task automatic drive(input logic we, input logic [4:0] wa, input logic [DW-1:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [DW-1:0] md);
    c_we = we; c_wa = wa; c_wd = wd; c_mv = mv; c_ma = ma; c_md = md;
    bus.WB_we_i = we; bus.WB_rd_addr_i = wa; bus.WB_writeback_data_i = wd;
    bus.MC_valid_i = mv; bus.MC_rd_addr_i = ma; bus.MC_data_i = md;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic we, input logic [4:0] wa,
                           input logic [DW-1:0] wd, input logic rdy, input logic stl,
                           input logic [DEPTH-1:0] pv);
    chk({tag, ".RF_we"},    64'(bus.RF_we_o),      64'(we));
    chk({tag, ".RF_waddr"}, 64'(bus.RF_waddr_o),   64'(wa));
    chk({tag, ".RF_wdata"}, 64'(bus.RF_wdata_o),   64'(wd));
    chk({tag, ".ready"},    64'(bus.MC_ready_o),   64'(rdy));
    chk({tag, ".stall"},    64'(bus.stall_o),      64'(stl));
    chk({tag, ".pend_v"},   64'(bus.pend_valid_o), 64'(pv));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    step();
    rst = 1'b0;
    q.delete(); pops = 0; sc = 0;
  endtask

  // expected outputs for the current cycle, from model state + stimulus
  task automatic model_check(input string tag);
    logic          stl, busy, e_we;
    logic [4:0]    e_wa;
    logic [DW-1:0] e_wd;
    logic [DEPTH-1:0]   pv;
    logic [5*DEPTH-1:0] prd;
    stl  = STARVE && (sc == LIMIT);
    busy = c_we && (c_wa != 0);
    e_we = 1'b0; e_wa = '0; e_wd = '0;
    if ((stl || !busy) && q.size() > 0) begin
      e_we = 1'b1; e_wa = q[0].a; e_wd = q[0].d;
    end else if (busy) begin
      e_we = 1'b1; e_wa = c_wa; e_wd = c_wd;
    end
    pv = '0; prd = '0;
    for (int k = 0; k < q.size(); k++) begin
      pv[(pops + k) % DEPTH] = 1'b1;
      prd[5*((pops + k) % DEPTH) +: 5] = q[k].a;
    end
    check_out(tag, e_we, e_wa, e_wd, q.size() < DEPTH, stl, pv);
    chk({tag, ".pend_rd"}, 64'(bus.pend_rd_o), 64'(prd));
  endtask

  task automatic model_update(input logic r);
    logic stl, busy, pop, rdy;
    ent_t e;
    if (r) begin
      q.delete(); pops = 0; sc = 0;
      return;
    end
    stl  = STARVE && (sc == LIMIT);
    busy = c_we && (c_wa != 0);
    rdy  = q.size() < DEPTH;
    pop  = (q.size() > 0) && (stl || !busy);
    if (STARVE) begin
      if (q.size() == 0 || pop) sc = 0;
      else if (sc < LIMIT)      sc = sc + 1;
    end
    if (pop) begin
      void'(q.pop_front());
      pops++;
    end
    if (c_mv && rdy && c_ma != 0) begin
      e.a = c_ma; e.d = c_md;
      q.push_back(e);
    end
  endtask

  initial begin
    //            we wa  wd         mv ma   md          e_we e_wa e_wd      rdy pv
    tbl[0]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 2'b00};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd5,  32'h1234, 1'b0, 5'd0,  32'h0,    1'b1, 2'b00};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 5'd5,  32'h1234, 1'b1, 2'b01};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 2'b00};
    tbl[4]  = '{1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd7,  32'h1,    1'b1, 5'd3,  32'hAAAA, 1'b1, 2'b00};
    tbl[5]  = '{1'b1, 5'd3, 32'hAAAA, 1'b0, 5'd0,  32'h0,    1'b1, 5'd3,  32'hAAAA, 1'b1, 2'b10};
    tbl[6]  = '{1'b1, 5'd3, 32'hAAAA, 1'b0, 5'd0,  32'h0,    1'b1, 5'd3,  32'hAAAA, 1'b1, 2'b10};
    tbl[7]  = '{1'b1, 5'd3, 32'hAAAA, 1'b0, 5'd0,  32'h0,    1'b1, 5'd3,  32'hAAAA, 1'b1, 2'b10};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 5'd7,  32'h1,    1'b1, 2'b10};
    tbl[9]  = '{1'b1, 5'd1, 32'h11,   1'b1, 5'd8,  32'h88,   1'b1, 5'd1,  32'h11,   1'b1, 2'b00};
    tbl[10] = '{1'b1, 5'd1, 32'h11,   1'b1, 5'd9,  32'h99,   1'b1, 5'd1,  32'h11,   1'b1, 2'b01};
    tbl[11] = '{1'b1, 5'd1, 32'h11,   1'b1, 5'd10, 32'hAA,   1'b1, 5'd1,  32'h11,   1'b0, 2'b11};
    tbl[12] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd10, 32'hAA,   1'b1, 5'd8,  32'h88,   1'b0, 2'b11};
    tbl[13] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd10, 32'hAA,   1'b1, 5'd9,  32'h99,   1'b1, 2'b10};
    tbl[14] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 5'd10, 32'hAA,   1'b1, 2'b01};
    tbl[15] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 2'b00};
    tbl[16] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd0,  32'hDEAD, 1'b0, 5'd0,  32'h0,    1'b1, 2'b00};
    tbl[17] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 2'b00};
    tbl[18] = '{1'b1, 5'd0, 32'h5,    1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 2'b00};

    do_reset();

    // directed table, one row per cycle
    for (int r = 0; r < 19; r++) begin
      drive(tbl[r].we, tbl[r].wa, tbl[r].wd, tbl[r].mv, tbl[r].ma, tbl[r].md);
      #3;
      check_out($sformatf("vec%0d", r), tbl[r].e_we, tbl[r].e_wa, tbl[r].e_wd,
                tbl[r].e_rdy, 1'b0, tbl[r].e_pv);
      step();
    end

    // reset with two entries pending drops them
    do_reset();
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'h44); step();
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd6, 32'h66); step();
    #3;
    chk("rst.pre_pend_v", 64'(bus.pend_valid_o), 64'(2'b11));
    rst = 1'b1;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    step();
    rst = 1'b0;
    #3;
    check_out("rst.post", 1'b0, 5'd0, '0, 1'b1, 1'b0, 2'b00);
    step();

`ifdef WB_ARB_STARVE_EN
    // WB busy every cycle with one result pending from cycle 1
    do_reset();
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'h44);
    step();
    drive(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, '0);
    for (int c = 1; c <= 8; c++) begin
      #3;
      check_out($sformatf("starve.c%0d", c), 1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 2'b01);
      step();
    end
    #3;
    check_out("starve.c9", 1'b1, 5'd4, 32'h44, 1'b1, 1'b1, 2'b01);
    step();
    #3;
    check_out("starve.c10", 1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 2'b00);
    step();
`endif

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic r;
      r = ($urandom_range(0, 199) == 0);
      rst = r;
      drive($urandom_range(0, 99) < 75, 5'($urandom_range(0, 31)), DW'($urandom),
            $urandom_range(0, 99) < 40,
            ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), DW'($urandom));
      #3;
      model_check($sformatf("rnd%0d", n));
      @(posedge clk);
      model_update(r);
      #1;
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
